id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage that sits directly downstream of the register file read ports.
- Drives the regfile read addresses from the IF/ID instruction and captures the read data into the ID/EX register.
- Detects load-use hazards and generates the stall for PC and IF/ID.
- Computes registered forwarding selects that the EX operand muxes consume.
- Regfile writes on the clock negedge, so a WB-stage write is visible to an ID read in the same cycle; no WB-to-ID bypass is needed here.

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection and registered forwarding selects.
// One-cycle latency ID->EX; o_stall holds PC and IF/ID and inserts one bubble per hazard, flush overrides stall.
module id_ex_stage #(
  parameter bit          ENABLE_FWD = 1'b1,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_id_valid,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_id_instr,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_mem_rd_addr,
  input  logic        i_mem_rd_wren,
  output logic        o_stall,
  output logic        o_ex_valid,
  output logic [31:0] o_ex_pc,
  output logic [31:0] o_ex_instr,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output logic [4:0]  o_ex_rd_addr,
  output logic        o_ex_rd_wren,
  output logic        o_ex_is_load,
  output logic [1:0]  o_ex_fwd_a,
  output logic [1:0]  o_ex_fwd_b,
  output logic [31:0] o_stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  logic [6:0] opcode;
  logic [4:0] rd_addr;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       rd_wren;
  logic       is_load;
  logic       ex_hit1;
  logic       ex_hit2;
  logic       mem_hit1;
  logic       mem_hit2;
  logic       hazard;
  logic       capture;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign opcode     = i_id_instr[6:0];
  assign rd_addr    = i_id_instr[11:7];
  assign o_rs1_addr = i_id_instr[19:15];
  assign o_rs2_addr = i_id_instr[24:20];

  assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2 = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
  assign rd_wren  = !(opcode inside {OP_STORE, OP_BRANCH}) && (rd_addr != 5'd0);
  assign is_load  = (opcode == OP_LOAD);

  function automatic logic src_hit(input logic used, input logic [4:0] src,
                                   input logic [4:0] dst, input logic wren);
    return used && (src != 5'd0) && wren && (src == dst);
  endfunction

  // EX only counts when it holds a real instruction; bubbles already carry rd_wren = 0
  assign ex_hit1  = src_hit(uses_rs1, o_rs1_addr, o_ex_rd_addr, o_ex_valid & o_ex_rd_wren);
  assign ex_hit2  = src_hit(uses_rs2, o_rs2_addr, o_ex_rd_addr, o_ex_valid & o_ex_rd_wren);
  assign mem_hit1 = src_hit(uses_rs1, o_rs1_addr, i_mem_rd_addr, i_mem_rd_wren);
  assign mem_hit2 = src_hit(uses_rs2, o_rs2_addr, i_mem_rd_addr, i_mem_rd_wren);

  always_comb begin
    hazard = 1'b0;
    fwd_a  = 2'b00;
    fwd_b  = 2'b00;
    if (ENABLE_FWD) begin
      hazard = o_ex_is_load & (ex_hit1 | ex_hit2);
      if (ex_hit1 && !o_ex_is_load) fwd_a = 2'b01;
      else if (mem_hit1)            fwd_a = 2'b10;
      if (ex_hit2 && !o_ex_is_load) fwd_b = 2'b01;
      else if (mem_hit2)            fwd_b = 2'b10;
    end else begin
      hazard = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2;
    end
  end

  assign o_stall = i_id_valid & hazard & ~i_flush;
  assign capture = i_id_valid & ~hazard & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ex_valid    <= 1'b0;
      o_ex_pc       <= 32'd0;
      o_ex_instr    <= NOP_INSTR;
      o_ex_rs1_data <= 32'd0;
      o_ex_rs2_data <= 32'd0;
      o_ex_rd_addr  <= 5'd0;
      o_ex_rd_wren  <= 1'b0;
      o_ex_is_load  <= 1'b0;
      o_ex_fwd_a    <= 2'b00;
      o_ex_fwd_b    <= 2'b00;
      o_stall_cnt   <= 32'd0;
    end else begin
      if (o_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (capture) begin
        o_ex_valid    <= 1'b1;
        o_ex_pc       <= i_id_pc;
        o_ex_instr    <= i_id_instr;
        o_ex_rs1_data <= i_rs1_data;
        o_ex_rs2_data <= i_rs2_data;
        o_ex_rd_addr  <= rd_addr;
        o_ex_rd_wren  <= rd_wren;
        o_ex_is_load  <= is_load;
        o_ex_fwd_a    <= fwd_a;
        o_ex_fwd_b    <= fwd_b;
      end else begin
        o_ex_valid    <= 1'b0;
        o_ex_pc       <= 32'd0;
        o_ex_instr    <= NOP_INSTR;
        o_ex_rs1_data <= 32'd0;
        o_ex_rs2_data <= 32'd0;
        o_ex_rd_addr  <= 5'd0;
        o_ex_rd_wren  <= 1'b0;
        o_ex_is_load  <= 1'b0;
        o_ex_fwd_a    <= 2'b00;
        o_ex_fwd_b    <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Random and directed checks of id_ex_stage with forwarding on (u0) and off (u1) against a behavioural pipeline model.
module tb_id_ex_stage;

  logic i_clk;
  logic i_rst_n;

  logic        flush [2];
  logic        vld   [2];
  logic [31:0] pc    [2];
  logic [31:0] instr [2];
  logic [31:0] d1    [2];
  logic [31:0] d2    [2];
  logic [4:0]  mrd   [2];
  logic        mwr   [2];

  logic [4:0]  rs1a [2];
  logic [4:0]  rs2a [2];
  logic        stl  [2];
  logic        ev   [2];
  logic [31:0] epc  [2];
  logic [31:0] ein  [2];
  logic [31:0] ed1  [2];
  logic [31:0] ed2  [2];
  logic [4:0]  erd  [2];
  logic        ewr  [2];
  logic        eld  [2];
  logic [1:0]  efa  [2];
  logic [1:0]  efb  [2];
  logic [31:0] ecnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_stage #(.ENABLE_FWD(g == 0), .NOP_INSTR(32'h0000_0013)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(flush[g]), .i_id_valid(vld[g]),
      .i_id_pc(pc[g]), .i_id_instr(instr[g]), .o_rs1_addr(rs1a[g]), .o_rs2_addr(rs2a[g]),
      .i_rs1_data(d1[g]), .i_rs2_data(d2[g]), .i_mem_rd_addr(mrd[g]), .i_mem_rd_wren(mwr[g]),
      .o_stall(stl[g]), .o_ex_valid(ev[g]), .o_ex_pc(epc[g]), .o_ex_instr(ein[g]),
      .o_ex_rs1_data(ed1[g]), .o_ex_rs2_data(ed2[g]), .o_ex_rd_addr(erd[g]),
      .o_ex_rd_wren(ewr[g]), .o_ex_is_load(eld[g]), .o_ex_fwd_a(efa[g]), .o_ex_fwd_b(efb[g]),
      .o_stall_cnt(ecnt[g])
    );
  end

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: what EX should hold, what MEM holds, and the expected stall count
  bit          m_v   [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_ins [2];
  logic [31:0] m_d1  [2];
  logic [31:0] m_d2  [2];
  logic [4:0]  m_rd  [2];
  bit          m_wr  [2];
  bit          m_ld  [2];
  logic [1:0]  m_fa  [2];
  logic [1:0]  m_fb  [2];
  logic [4:0]  mm_rd [2];
  bit          mm_wr [2];
  logic [31:0] m_cnt [2];
  bit          m_stall [2];
  logic [1:0]  nfa [2];
  logic [1:0]  nfb [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %h, expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] a, input logic [4:0] b);
    return {f7, b, a, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] a);
    return {12'd0, a, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd);
    return {20'h12345, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: op = 7'b0110111;
      1: op = 7'b0010111;
      2: op = 7'b1101111;
      3: op = 7'b1100111;
      4: op = 7'b1100011;
      5: op = 7'b0000011;
      6: op = 7'b0100011;
      7: op = 7'b0010011;
      default: op = 7'b0110011;
    endcase
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic model_bubble(input int k);
    m_v[k] = 0; m_pc[k] = 0; m_ins[k] = 32'h13; m_d1[k] = 0; m_d2[k] = 0;
    m_rd[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_bubble(k);
      mm_rd[k] = 0; mm_wr[k] = 0; m_cnt[k] = 0; m_stall[k] = 0;
      mrd[k] = 0; mwr[k] = 0;
    end
  endtask

  // Stall and forwarding expectations for the instruction now in ID
  task automatic model_comb(input int k);
    logic [6:0] op;
    logic [4:0] src [2];
    bit         used [2];
    bit         exh, memh, hz;
    logic [1:0] f [2];
    op = instr[k][6:0];
    src[0] = instr[k][19:15];
    src[1] = instr[k][24:20];
    used[0] = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    used[1] = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    hz = 0;
    for (int j = 0; j < 2; j++) begin
      exh  = used[j] && src[j] != 0 && m_v[k] && m_wr[k] && src[j] == m_rd[k];
      memh = used[j] && src[j] != 0 && mm_wr[k] && src[j] == mm_rd[k];
      if (k == 0) begin
        hz   = hz | (exh && m_ld[k]);
        f[j] = (exh && !m_ld[k]) ? 2'b01 : (memh ? 2'b10 : 2'b00);
      end else begin
        hz   = hz | exh | memh;
        f[j] = 2'b00;
      end
    end
    m_stall[k] = vld[k] && hz && !flush[k];
    nfa[k] = f[0];
    nfb[k] = f[1];
  endtask

  task automatic model_edge(input int k);
    logic [6:0] op;
    op = instr[k][6:0];
    mm_rd[k] = m_rd[k];
    mm_wr[k] = m_v[k] && m_wr[k];
    if (m_stall[k]) m_cnt[k] = m_cnt[k] + 32'd1;
    if (flush[k] || m_stall[k] || !vld[k]) model_bubble(k);
    else begin
      m_v[k] = 1; m_pc[k] = pc[k]; m_ins[k] = instr[k]; m_d1[k] = d1[k]; m_d2[k] = d2[k];
      m_rd[k] = instr[k][11:7];
      m_wr[k] = !(op inside {7'b0100011, 7'b1100011}) && instr[k][11:7] != 0;
      m_ld[k] = (op == 7'b0000011);
      m_fa[k] = nfa[k]; m_fb[k] = nfb[k];
    end
  endtask

  task automatic check_regs(input int k);
    chk("ex_valid", k, 32'(ev[k]), 32'(m_v[k]));
    chk("ex_pc", k, epc[k], m_pc[k]);
    chk("ex_instr", k, ein[k], m_ins[k]);
    chk("ex_rs1_data", k, ed1[k], m_d1[k]);
    chk("ex_rs2_data", k, ed2[k], m_d2[k]);
    chk("ex_rd_addr", k, 32'(erd[k]), 32'(m_rd[k]));
    chk("ex_rd_wren", k, 32'(ewr[k]), 32'(m_wr[k]));
    chk("ex_is_load", k, 32'(eld[k]), 32'(m_ld[k]));
    chk("ex_fwd_a", k, 32'(efa[k]), 32'(m_fa[k]));
    chk("ex_fwd_b", k, 32'(efb[k]), 32'(m_fb[k]));
    chk("stall_cnt", k, ecnt[k], m_cnt[k]);
  endtask

  // Inputs are stable here; check the combinational outputs
  task automatic settle();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_comb(k);
      chk("rs1_addr", k, 32'(rs1a[k]), 32'(instr[k][19:15]));
      chk("rs2_addr", k, 32'(rs2a[k]), 32'(instr[k][24:20]));
      chk("stall", k, 32'(stl[k]), 32'(m_stall[k]));
    end
  endtask

  task automatic clk_step();
    @(posedge i_clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_regs(k);
      mrd[k] = mm_rd[k];
      mwr[k] = mm_wr[k];
    end
  endtask

  task automatic dir(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b, input bit fl);
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b1; flush[k] = fl; instr[k] = w; d1[k] = a; d2[k] = b; pc[k] = pc[k] + 32'd4;
    end
    settle();
  endtask

  initial begin
    i_rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; vld[k] = 0; pc[k] = 32'h100; instr[k] = 32'h13; d1[k] = 0; d2[k] = 0;
    end
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) check_regs(k);
    chk("rst_instr", 0, ein[0], 32'h0000_0013);
    chk("rst_valid", 0, 32'(ev[0]), 32'd0);
    i_rst_n = 1'b1;

    // Plain flow
    dir(enc_r(7'h00, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 0); clk_step();
    chk("plain_rs1", 0, ed1[0], 32'd5);
    chk("plain_rs2", 0, ed2[0], 32'd7);
    chk("plain_rd", 0, 32'(erd[0]), 32'd3);
    chk("plain_wren", 0, 32'(ewr[0]), 32'd1);
    chk("plain_fwd_a", 0, 32'(efa[0]), 32'd0);
    // Back-to-back dependency: EX forward with forwarding, stall without
    dir(enc_r(7'h20, 5'd4, 5'd3, 5'd3), 32'd1, 32'd2, 0);
    chk("ex_dep_stall", 0, 32'(stl[0]), 32'd0);
    chk("nofwd_ex_stall", 1, 32'(stl[1]), 32'd1);
    clk_step();
    chk("ex_fwd_a", 0, 32'(efa[0]), 32'd1);
    chk("ex_fwd_b", 0, 32'(efb[0]), 32'd1);
    // One-instruction gap: MEM forward
    dir(enc_r(7'h00, 5'd3, 5'd1, 5'd2), 32'd9, 32'd9, 0); clk_step();
    dir(32'h0000_0013, 32'd0, 32'd0, 0); clk_step();
    dir(enc_r(7'h20, 5'd5, 5'd3, 5'd3), 32'd3, 32'd4, 0);
    chk("nofwd_mem_stall", 1, 32'(stl[1]), 32'd1);
    clk_step();
    chk("mem_fwd_a", 0, 32'(efa[0]), 32'd2);
    chk("mem_fwd_b", 0, 32'(efb[0]), 32'd2);
    // EX and MEM both write x3: EX wins
    dir(enc_r(7'h00, 5'd3, 5'd1, 5'd2), 32'd1, 32'd1, 0); clk_step();
    dir(enc_r(7'h00, 5'd3, 5'd1, 5'd2), 32'd2, 32'd2, 0); clk_step();
    dir(enc_r(7'h20, 5'd6, 5'd3, 5'd3), 32'd3, 32'd3, 0); clk_step();
    chk("prio_fwd_a", 0, 32'(efa[0]), 32'd1);
    chk("prio_fwd_b", 0, 32'(efb[0]), 32'd1);
    // Load-use: one stall, then MEM forward on the retry
    dir(enc_lw(5'd5, 5'd1), 32'd0, 32'd0, 0); clk_step();
    dir(enc_r(7'h00, 5'd6, 5'd5, 5'd2), 32'd8, 32'd8, 0);
    chk("lu_stall", 0, 32'(stl[0]), 32'd1);
    clk_step();
    chk("lu_bubble", 0, 32'(ev[0]), 32'd0);
    dir(enc_r(7'h00, 5'd6, 5'd5, 5'd2), 32'd8, 32'd8, 0);
    chk("lu_retry_stall", 0, 32'(stl[0]), 32'd0);
    clk_step();
    chk("lu_fwd_a", 0, 32'(efa[0]), 32'd2);
    chk("lu_fwd_b", 0, 32'(efb[0]), 32'd0);
    chk("lu_cnt", 0, ecnt[0], 32'd1);
    // Flush beats stall
    dir(enc_lw(5'd5, 5'd1), 32'd0, 32'd0, 0); clk_step();
    dir(enc_r(7'h00, 5'd6, 5'd5, 5'd2), 32'd8, 32'd8, 1);
    chk("flush_stall", 0, 32'(stl[0]), 32'd0);
    clk_step();
    chk("flush_bubble", 0, 32'(ev[0]), 32'd0);
    chk("flush_cnt", 0, ecnt[0], 32'd1);
    // x0 destination and non-users never stall
    dir(enc_lw(5'd0, 5'd1), 32'd0, 32'd0, 0); clk_step();
    dir(enc_r(7'h00, 5'd1, 5'd0, 5'd0), 32'd0, 32'd0, 0);
    chk("x0_stall", 0, 32'(stl[0]), 32'd0);
    clk_step();
    chk("x0_fwd_a", 0, 32'(efa[0]), 32'd0);
    dir(enc_lw(5'd7, 5'd1), 32'd0, 32'd0, 0); clk_step();
    dir(enc_lui(5'd7), 32'd0, 32'd0, 0);
    chk("lui_stall", 0, 32'(stl[0]), 32'd0);
    clk_step();
    chk("lui_fwd_a", 0, 32'(efa[0]), 32'd0);

    // Asynchronous reset mid-cycle with a load in EX
    dir(enc_lw(5'd5, 5'd0), 32'd0, 32'd0, 0); clk_step();
    chk("pre_rst_load", 0, 32'(eld[0]), 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 0, 32'(ev[0]), 32'd0);
    chk("arst_instr", 0, ein[0], 32'h0000_0013);
    chk("arst_fwd_a", 0, 32'(efa[0]), 32'd0);
    chk("arst_cnt", 0, ecnt[0], 32'd0);
    for (int k = 0; k < 2; k++) check_regs(k);
    #1 i_rst_n = 1'b1;

    // Randomised traffic; IF/ID holds its instruction while stalled
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_stall[k]) begin
          instr[k] = rand_instr();
          pc[k]    = $urandom;
        end
        vld[k]   = ($urandom_range(0, 9) != 0);
        flush[k] = ($urandom_range(0, 11) == 0);
        d1[k]    = $urandom;
        d2[k]    = $urandom;
      end
      settle();
      clk_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
